// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard / branch / memory-wait controller.
//
// Decides, every cycle, whether the five-stage pipeline runs, stalls for a
// data hazard, flushes for a taken branch, or freezes for a pending memory
// access. A memory access that waits MEM_TIMEOUT consecutive cycles moves
// the controller into a sticky ERR state that only rst leaves.
//
// Parameters:
//   MEM_TIMEOUT  consecutive memory-wait cycles before a fault (1..255)
//
// Optional feature macro:
//   PIPE_CTRL_PERF_CNT_EN  adds stall_cnt / flush_cnt performance counters
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_valid                 ID stage holds a real instruction
//   id_src1, id_src2         ID source registers
//   id_two_src               instruction also reads id_src2
//   exe_wb_en, exe_dest      EXE-stage writeback
//   mem_wb_en, mem_dest      MEM-stage writeback
//   exe_branch               taken branch resolved in EXE
//   mem_req, mem_ready       MEM access pending / memory done
//   if_freeze                hold PC and IF/ID
//   ifid_flush               clear IF/ID
//   idexe_flush              bubble into ID/EXE
//   pipe_freeze              hold every pipeline register
//   mem_err                  sticky memory-timeout fault
//   state                    FSM state: RUN=0, HAZ=1, MEMW=2, ERR=3
//   stall_cnt, flush_cnt     (macro only) cycles with if_freeze, branch flushes
//
// Handshake: mem_req/mem_ready is a level protocol -- a cycle with
// mem_req=1 and mem_ready=0 is a wait cycle; mem_ready=1 completes the
// access in that same cycle, with no wait counted for it.

module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_two_src,
    input  logic        exe_wb_en,
    input  logic [3:0]  exe_dest,
    input  logic        mem_wb_en,
    input  logic [3:0]  mem_dest,
    input  logic        exe_branch,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        if_freeze,
    output logic        ifid_flush,
    output logic        idexe_flush,
    output logic        pipe_freeze,
    output logic        mem_err,
    output logic [1:0]  state
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HAZ  = 2'd1;
    localparam logic [1:0] ST_MEMW = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    // Counter value seen on the last tolerated wait cycle.
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    logic [1:0] state_q;
    logic [1:0] state_n;
    logic [7:0] wait_cnt;
    logic       hazard;
    logic       mem_wait;

    assign state = state_q;

    assign mem_wait = mem_req & ~mem_ready;

    assign hazard = id_valid &
                    ((exe_wb_en & (exe_dest == id_src1)) |
                     (mem_wb_en & (mem_dest == id_src1)) |
                     (id_two_src &
                      ((exe_wb_en & (exe_dest == id_src2)) |
                       (mem_wb_en & (mem_dest == id_src2)))));

    // Priority: ERR, memory wait, branch, hazard. A branch squashes the
    // instruction in ID anyway, so a simultaneous hazard is moot.
    always_comb begin
        if_freeze   = 1'b0;
        ifid_flush  = 1'b0;
        idexe_flush = 1'b0;
        pipe_freeze = 1'b0;
        state_n     = ST_RUN;

        if (state_q == ST_ERR) begin
            if_freeze   = 1'b1;
            pipe_freeze = 1'b1;
            state_n     = ST_ERR;
        end else if (mem_wait) begin
            if_freeze   = 1'b1;
            pipe_freeze = 1'b1;
            state_n     = (wait_cnt == WAIT_LIMIT) ? ST_ERR : ST_MEMW;
        end else if (exe_branch) begin
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
            state_n     = ST_RUN;
        end else if (hazard) begin
            if_freeze   = 1'b1;
            idexe_flush = 1'b1;
            state_n     = ST_HAZ;
        end

        // Controls are quiet while reset is asserted.
        if (rst) begin
            if_freeze   = 1'b0;
            ifid_flush  = 1'b0;
            idexe_flush = 1'b0;
            pipe_freeze = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            state_q <= state_n;
            // ERR is terminal, so the fault flag simply follows it.
            mem_err <= (state_n == ST_ERR);
            if (mem_wait && state_q != ST_ERR) begin
                if (wait_cnt != 8'hFF) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end else begin
                wait_cnt <= 8'd0;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    // Both counters wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            stall_cnt <= stall_cnt + 16'(if_freeze);
            flush_cnt <= flush_cnt + 16'(ifid_flush);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int TMO = 4;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_two_src;
  logic       exe_wb_en;
  logic [3:0] exe_dest;
  logic       mem_wb_en;
  logic [3:0] mem_dest;
  logic       exe_branch;
  logic       mem_req;
  logic       mem_ready;
  logic       if_freeze;
  logic       ifid_flush;
  logic       idexe_flush;
  logic       pipe_freeze;
  logic       mem_err;
  logic [1:0] state;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int checks;
  int failures;

  // Reference model state
  logic        m_err;
  int          m_waits;
  logic [1:0]  m_state;
  logic [15:0] m_stall;
  logic [15:0] m_flush;

  wire [3:0] ctrl = {if_freeze, ifid_flush, idexe_flush, pipe_freeze};

  pipe_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .exe_wb_en   (exe_wb_en),
    .exe_dest    (exe_dest),
    .mem_wb_en   (mem_wb_en),
    .mem_dest    (mem_dest),
    .exe_branch  (exe_branch),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .if_freeze   (if_freeze),
    .ifid_flush  (ifid_flush),
    .idexe_flush (idexe_flush),
    .pipe_freeze (pipe_freeze),
    .mem_err     (mem_err),
    .state       (state)
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic m_hazard();
    logic s1_hit, s2_hit;
    s1_hit = (exe_wb_en && exe_dest == id_src1) || (mem_wb_en && mem_dest == id_src1);
    s2_hit = (exe_wb_en && exe_dest == id_src2) || (mem_wb_en && mem_dest == id_src2);
    return id_valid && (s1_hit || (id_two_src && s2_hit));
  endfunction

  // {if_freeze, ifid_flush, idexe_flush, pipe_freeze}
  function automatic logic [3:0] m_ctrl();
    if (rst) return 4'b0000;
    if (m_err || (mem_req && !mem_ready)) return 4'b1001;
    if (exe_branch) return 4'b0110;
    if (m_hazard()) return 4'b1010;
    return 4'b0000;
  endfunction

  // Advance the model with the current inputs, then cross the clock edge.
  task automatic tick();
    logic [3:0] c;
    c = m_ctrl();
    if (rst) begin
      m_err = 1'b0; m_waits = 0; m_state = 2'd0; m_stall = 16'd0; m_flush = 16'd0;
    end else begin
      m_stall = m_stall + 16'(c[3]);
      m_flush = m_flush + 16'(c[2]);
      if (!m_err) begin
        if (mem_req && !mem_ready) begin
          m_waits = m_waits + 1;
          if (m_waits >= TMO) begin
            m_err = 1'b1; m_state = 2'd3;
          end else begin
            m_state = 2'd2;
          end
        end else begin
          m_waits = 0;
          m_state = (!exe_branch && m_hazard()) ? 2'd1 : 2'd0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic two, input logic ewb, input logic [3:0] ed,
                       input logic mwb, input logic [3:0] md,
                       input logic br, input logic mrq, input logic mrd);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    exe_wb_en = ewb; exe_dest = ed; mem_wb_en = mwb; mem_dest = md;
    exe_branch = br; mem_req = mrq; mem_ready = mrd;
  endtask

  task automatic drive_random(input int reg_max);
    drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, reg_max)), 4'($urandom_range(0, reg_max)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, reg_max)),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, reg_max)),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4));
  endtask

  task automatic clear_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_random(15);
      #1;
      checks++;
      if (ctrl !== 4'b0000) begin
        failures++; $display("FAIL reset_ctrl got=%b exp=0000", ctrl);
      end
      tick();
      checks++;
      if (state !== 2'd0 || mem_err !== 1'b0) begin
        failures++; $display("FAIL reset_state got state=%0d err=%b exp state=0 err=0", state, mem_err);
      end
    end
    rst = 1'b0;
    clear_in();
    tick();
  endtask

  task automatic test_hazard();
    drive(1, 3, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (ctrl !== 4'b1010) begin
      failures++; $display("FAIL hazard_ctrl got=%b exp=1010", ctrl);
    end
    tick();
    checks++;
    if (state !== 2'd1) begin
      failures++; $display("FAIL hazard_state got=%0d exp=1", state);
    end
    // Same hazard, but on id_src2 with id_two_src set, via the MEM stage.
    drive(1, 7, 9, 1, 0, 0, 1, 9, 0, 0, 0);
    #1;
    checks++;
    if (ctrl !== 4'b1010) begin
      failures++; $display("FAIL hazard_src2_ctrl got=%b exp=1010", ctrl);
    end
    clear_in();
    tick();
  endtask

  task automatic test_branch();
    drive(1, 3, 0, 0, 1, 3, 0, 0, 1, 0, 0);
    #1;
    checks++;
    if (ctrl !== 4'b0110) begin
      failures++; $display("FAIL branch_ctrl got=%b exp=0110", ctrl);
    end
    tick();
    checks++;
    if (state !== 2'd0) begin
      failures++; $display("FAIL branch_state got=%0d exp=0", state);
    end
    clear_in();
    tick();
  endtask

  task automatic test_no_hazard_one_src();
    drive(1, 0, 5, 0, 0, 0, 1, 5, 0, 0, 0);
    #1;
    checks++;
    if (ctrl !== 4'b0000) begin
      failures++; $display("FAIL one_src_ctrl got=%b exp=0000", ctrl);
    end
    tick();
    checks++;
    if (state !== 2'd0) begin
      failures++; $display("FAIL one_src_state got=%0d exp=0", state);
    end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      drive(1, 3, 0, 0, 1, 3, 0, 0, 1, 1, 0);
      #1;
      checks++;
      if (ctrl !== 4'b1001) begin
        failures++; $display("FAIL memwait_ctrl cycle=%0d got=%b exp=1001", i, ctrl);
      end
      tick();
      checks++;
      if (state !== 2'd2) begin
        failures++; $display("FAIL memwait_state cycle=%0d got=%0d exp=2", i, state);
      end
    end
    drive(1, 3, 0, 0, 1, 3, 0, 0, 1, 1, 1);
    #1;
    checks++;
    if (ctrl !== 4'b0110) begin
      failures++; $display("FAIL memwait_release_ctrl got=%b exp=0110", ctrl);
    end
    tick();
    checks++;
    if (state !== 2'd0) begin
      failures++; $display("FAIL memwait_release_state got=%0d exp=0", state);
    end
    clear_in();
    tick();
  endtask

  task automatic test_ready_at_limit();
    for (int i = 0; i < TMO - 1; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    checks++;
    if (ctrl !== 4'b0000) begin
      failures++; $display("FAIL limit_ready_ctrl got=%b exp=0000", ctrl);
    end
    tick();
    checks++;
    if (state !== 2'd0 || mem_err !== 1'b0) begin
      failures++; $display("FAIL limit_ready_state got state=%0d err=%b exp state=0 err=0", state, mem_err);
    end
    // The counter restarted, so one more wait must not fault.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    checks++;
    if (state !== 2'd2 || mem_err !== 1'b0) begin
      failures++; $display("FAIL limit_restart got state=%0d err=%b exp state=2 err=0", state, mem_err);
    end
    clear_in();
    tick();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < TMO; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      checks++;
      if (ctrl !== 4'b1001) begin
        failures++; $display("FAIL timeout_wait_ctrl cycle=%0d got=%b exp=1001", i, ctrl);
      end
      tick();
      checks++;
      if (state !== ((i == TMO - 1) ? 2'd3 : 2'd2) || mem_err !== (i == TMO - 1)) begin
        failures++; $display("FAIL timeout_wait_state cycle=%0d got state=%0d err=%b", i, state, mem_err);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive_random(15);
      mem_ready = 1'b1;
      #1;
      checks++;
      if (ctrl !== 4'b1001) begin
        failures++; $display("FAIL err_ctrl cycle=%0d got=%b exp=1001", i, ctrl);
      end
      tick();
      checks++;
      if (state !== 2'd3 || mem_err !== 1'b1) begin
        failures++; $display("FAIL err_sticky cycle=%0d got state=%0d err=%b exp state=3 err=1", i, state, mem_err);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ctrl !== 4'b0000) begin
      failures++; $display("FAIL err_rst_ctrl got=%b exp=0000", ctrl);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (state !== 2'd0 || mem_err !== 1'b0) begin
      failures++; $display("FAIL err_rst_state got state=%0d err=%b exp state=0 err=0", state, mem_err);
    end
    clear_in();
    tick();
  endtask

`ifdef PIPE_CTRL_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1, 3, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    tick();
    tick();
    drive(1, 3, 0, 0, 1, 3, 0, 0, 1, 0, 0);
    tick();
    clear_in();
    tick();
    checks++;
    if (stall_cnt !== 16'd2 || flush_cnt !== 16'd1) begin
      failures++; $display("FAIL perf_cnt got stall=%0d flush=%0d exp stall=2 flush=1", stall_cnt, flush_cnt);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive_random(3);
      rst = ($urandom_range(0, 59) == 0) || (m_err && $urandom_range(0, 5) == 0);
      // Occasionally hold a long wait to reach the timeout.
      if (i % 97 == 50) begin
        mem_req = 1'b1; mem_ready = 1'b0;
      end
      #1;
      checks++;
      if (ctrl !== m_ctrl()) begin
        failures++; $display("FAIL rand_ctrl cycle=%0d got=%b exp=%b", i, ctrl, m_ctrl());
      end
      tick();
      checks++;
      if (state !== m_state || mem_err !== m_err) begin
        failures++; $display("FAIL rand_state cycle=%0d got state=%0d err=%b exp state=%0d err=%b",
                             i, state, mem_err, m_state, m_err);
      end
`ifdef PIPE_CTRL_PERF_CNT_EN
      checks++;
      if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
        failures++; $display("FAIL rand_perf cycle=%0d got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                             i, stall_cnt, flush_cnt, m_stall, m_flush);
      end
`endif
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    failures = 0;
    m_err = 1'b0; m_waits = 0; m_state = 2'd0; m_stall = 16'd0; m_flush = 16'd0;
    rst = 1'b1;
    clear_in();
    @(posedge clk);
    #1;
    test_reset();
    test_hazard();
    test_branch();
    test_no_hazard_one_src();
    test_mem_wait();
    test_ready_at_limit();
    test_timeout();
`ifdef PIPE_CTRL_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum consecutive memory-wait cycles tolerated before a fault is declared (legal 1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 id_valid  in  1  ID stage holds a real instruction.
REQ-005 id_src1, id_src2  in  4 each  ID source register numbers.
REQ-006 id_two_src  in  1  instruction reads id_src2 (register Rm or store data).
REQ-007 exe_wb_en, exe_dest  in  1/4  EXE-stage writeback enable and destination.
REQ-008 mem_wb_en, mem_dest  in  1/4  MEM-stage writeback enable and destination.
REQ-009 exe_branch  in  1  taken branch resolved in EXE this cycle.
REQ-010 mem_req, mem_ready  in  1/1  MEM stage access pending; memory done.
REQ-011 if_freeze  out  1  hold PC and IF/ID register.
REQ-012 ifid_flush  out  1  clear IF/ID register.
REQ-013 idexe_flush  out  1  drive ID/EXE register flush (insert bubble).
REQ-014 pipe_freeze  out  1  hold every pipeline register (memory wait).
REQ-015 mem_err  out  1  sticky memory-timeout fault.
REQ-016 state  out  2  FSM state: RUN=0, HAZ=1, MEMW=2, ERR=3.

Function
REQ-017 hazard = id_valid & ((exe_wb_en & exe_dest==id_src1) | (mem_wb_en & mem_dest==id_src1) | id_two_src & ((exe_wb_en & exe_dest==id_src2) | (mem_wb_en & mem_dest==id_src2))).
REQ-018 Control outputs SHALL be combinational from registered state and current inputs (zero-cycle latency); state, wait counter and mem_err SHALL be registered.
REQ-019 Priority, highest first: ERR, memory wait (mem_req & ~mem_ready), exe_branch, hazard.
REQ-020 Memory wait: pipe_freeze=1, if_freeze=1, both flushes 0; next state MEMW.
REQ-021 Branch (no memory wait): ifid_flush=1, idexe_flush=1, if_freeze=0; next state RUN; a simultaneous hazard SHALL be ignored.
REQ-022 Hazard (no wait, no branch): if_freeze=1, idexe_flush=1, ifid_flush=0; next state HAZ.
REQ-023 Otherwise all control outputs 0; next state RUN.
REQ-024 8-bit wait counter increments each cycle in memory wait, clears to 0 on any non-wait cycle; saturates at 255.
REQ-025 When a wait cycle occurs with counter == MEM_TIMEOUT-1, next state SHALL be ERR and mem_err SHALL set.
REQ-026 ERR: pipe_freeze=1, if_freeze=1, flushes 0, mem_err=1; exited only by rst.
REQ-027 mem_ready rising in the same cycle the counter would reach the limit SHALL NOT fault.

Reset
REQ-028 On rst at any edge, including mid-wait or in ERR: state=RUN, wait counter=0, mem_err=0, perf counters=0.
REQ-029 While rst is high all control outputs SHALL be 0.

Configuration
REQ-030 Macro PIPE_CTRL_PERF_CNT_EN defined: adds outputs stall_cnt[15:0] (increments each cycle if_freeze=1) and flush_cnt[15:0] (increments each branch flush), both wrapping 0xFFFF->0.
REQ-031 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 id_src1=3, exe_wb_en=1, exe_dest=3, id_valid=1 -> if_freeze=1, idexe_flush=1, state=HAZ next cycle.
REQ-033 Same hazard plus exe_branch=1 -> ifid_flush=1, idexe_flush=1, if_freeze=0, state=RUN.
REQ-034 mem_req=1, mem_ready=0 for 3 cycles then 1, hazard and branch also high -> pipe_freeze=1 for 3 cycles, no flushes; 4th cycle branch honoured.
REQ-035 MEM_TIMEOUT=4, mem_ready held 0 -> mem_err=1 and state=ERR after 4th wait cycle; stays until rst, then state=RUN, mem_err=0.
REQ-036 id_two_src=0, id_src2=5, mem_dest=5, mem_wb_en=1 -> no hazard, all outputs 0.
REQ-037 With PIPE_CTRL_PERF_CNT_EN: 2 hazard cycles + 1 branch -> stall_cnt=2, flush_cnt=1.
